// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blinker and its receive-side decoder.
// Holds the decoder FSM encoding and the 2-bit rate codes that both ends agree on.
package led_blink_pkg;

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no edge seen since reset
        ST_MEASURE = 2'd1,  // measuring half-periods, building up a lock
        ST_LOCKED  = 2'd2,  // rate code locked and being tracked
        ST_STUCK   = 2'd3   // line has not toggled for the timeout window
    } dec_state_e;

    // Rate codes, slowest blink first (same decode as the blinker's switches)
    localparam logic [1:0] RATE_SLOW     = 2'b00;
    localparam logic [1:0] RATE_MID_SLOW = 2'b01;
    localparam logic [1:0] RATE_MID_FAST = 2'b10;
    localparam logic [1:0] RATE_FAST     = 2'b11;

    // Width of the consecutive-match counter (lock threshold is 1..7)
    localparam int unsigned LOCK_CNT_W = 3;

    // Lowest-index set bit of a 4-bit hit vector; returns 0 when none is set,
    // so callers must qualify the result with |hits.
    function automatic logic [1:0] lowest_hit(input logic [3:0] hits);
        logic [1:0] code;
        code = RATE_SLOW;
        for (int i = 3; i >= 0; i--) begin
            if (hits[i]) begin
                code = 2'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/led_edge_sync.sv
// Brings the asynchronous blink line into the clk domain and flags toggles.
// Two synchronizer flops followed by a history flop; an edge is any
// difference between the last two synchronized samples.
module led_edge_sync (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic led_in,
    output logic led_sync,   // synchronized line level
    output logic led_edge    // one-cycle flag on every toggle
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Next-state for the shift chain: each stage copies the one before it
    always_comb begin
        s1_d = led_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and history registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign led_sync = s2_q;
    assign led_edge = s2_q ^ s3_q;

endmodule

// File: rtl/led_blink_decoder.sv
// Receive-side decoder for the LED blinker: measures the half-period between
// toggles of the sampled line, classifies it against four expected
// half-periods and reports a locked 2-bit rate code. A line that stops
// toggling for TIMEOUT cycles is reported as stuck together with its level.
module led_blink_decoder
    import led_blink_pkg::*;
#(
    parameter int unsigned CNT_W   = 27,
    parameter int unsigned HALF_P0 = 50000000,
    parameter int unsigned HALF_P1 = 25000000,
    parameter int unsigned HALF_P2 = 12500000,
    parameter int unsigned HALF_P3 = 6250000,
    parameter int unsigned TOL     = 1000,
    parameter int unsigned LOCK_N  = 2,
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             led_in,       // asynchronous blink line
    output logic [1:0]       rate,
    output logic             rate_valid,
    output logic             lock_pulse,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             stuck_level
);

    // Classification runs one bit wider than the counter so |m - P| never wraps
    localparam logic [CNT_W:0]       TOL_X      = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]     TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [LOCK_CNT_W-1:0] LOCK_N_C  = LOCK_CNT_W'(LOCK_N);
    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX  = {LOCK_CNT_W{1'b1}};

    genvar gi;

    // ------------------------------------------------------------------
    // Line synchronizer and edge detect
    // ------------------------------------------------------------------
    logic led_sync;
    logic led_edge;

    led_edge_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .led_in   (led_in),
        .led_sync (led_sync),
        .led_edge (led_edge)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    dec_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            cand_q, cand_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]            rate_q, rate_d;
    logic                  rate_valid_q, rate_valid_d;
    logic                  lock_pulse_q, lock_pulse_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic                  stuck_q, stuck_d;
    logic                  stuck_level_q, stuck_level_d;

    // ------------------------------------------------------------------
    // Classifier: the measurement is cnt_q in the cycle an edge is flagged
    // ------------------------------------------------------------------
    logic [CNT_W:0] meas_ext;
    logic [3:0]     hit;
    logic           meas_any;
    logic [1:0]     meas_code;

    assign meas_ext = {1'b0, cnt_q};

    for (gi = 0; gi < 4; gi++) begin : g_cls
        localparam int unsigned HP_I = (gi == 0) ? HALF_P0 :
                                       (gi == 1) ? HALF_P1 :
                                       (gi == 2) ? HALF_P2 : HALF_P3;
        localparam logic [CNT_W:0] HP = (CNT_W + 1)'(HP_I);
        logic [CNT_W:0] diff;

        assign diff   = (meas_ext >= HP) ? (meas_ext - HP) : (HP - meas_ext);
        assign hit[gi] = (diff <= TOL_X);
    end

    // Overlapping windows resolve to the lowest code
    assign meas_any  = |hit;
    assign meas_code = lowest_hit(hit);

    // ------------------------------------------------------------------
    // Next-state: half-period counter, lock tracking, stuck detection
    // ------------------------------------------------------------------
    always_comb begin
        logic [LOCK_CNT_W-1:0] lc_new;
        logic                  go_stuck;

        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        lock_cnt_d    = lock_cnt_q;
        rate_d        = rate_q;
        rate_valid_d  = rate_valid_q;
        lock_pulse_d  = 1'b0;
        period_d      = period_q;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;
        lc_new        = lock_cnt_q;
        go_stuck      = 1'b0;

        // Counter restarts at 1 on each edge, idles at 0, saturates otherwise
        if (led_edge) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // First edge only starts the counter; there is nothing to measure yet
                if (led_edge) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (led_edge) begin
                    period_d = cnt_q;
                    if (meas_any) begin
                        if (meas_code == cand_q) begin
                            lc_new = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX
                                                              : lock_cnt_q + LOCK_CNT_W'(1);
                        end else begin
                            lc_new = LOCK_CNT_W'(1);
                            cand_d = meas_code;
                        end
                        lock_cnt_d = lc_new;
                        if (lc_new >= LOCK_N_C) begin
                            rate_d       = cand_d;
                            rate_valid_d = 1'b1;
                            lock_pulse_d = 1'b1;
                            state_d      = ST_LOCKED;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    go_stuck = 1'b1;
                end
            end

            ST_LOCKED: begin
                if (led_edge) begin
                    period_d = cnt_q;
                    if (meas_any && (meas_code == cand_q)) begin
                        state_d = ST_LOCKED;
                    end else if (meas_any) begin
                        // Rate changed: restart the lock with the new code as candidate
                        rate_valid_d = 1'b0;
                        cand_d       = meas_code;
                        lock_cnt_d   = LOCK_CNT_W'(1);
                        state_d      = ST_MEASURE;
                    end else begin
                        rate_valid_d = 1'b0;
                        lock_cnt_d   = '0;
                        state_d      = ST_MEASURE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    go_stuck = 1'b1;
                end
            end

            ST_STUCK: begin
                // Track the line level; the edge that ends stuck is not measured
                stuck_level_d = led_sync;
                if (led_edge) begin
                    stuck_d       = 1'b0;
                    stuck_level_d = 1'b0;
                    state_d       = ST_MEASURE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_stuck) begin
            state_d       = ST_STUCK;
            stuck_d       = 1'b1;
            rate_valid_d  = 1'b0;
            lock_cnt_d    = '0;
            stuck_level_d = led_sync;
        end
    end

    // Register update; reset clears everything without waiting for clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cand_q        <= RATE_SLOW;
            lock_cnt_q    <= '0;
            rate_q        <= RATE_SLOW;
            rate_valid_q  <= 1'b0;
            lock_pulse_q  <= 1'b0;
            period_q      <= '0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            lock_cnt_q    <= lock_cnt_d;
            rate_q        <= rate_d;
            rate_valid_q  <= rate_valid_d;
            lock_pulse_q  <= lock_pulse_d;
            period_q      <= period_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign rate        = rate_q;
    assign rate_valid  = rate_valid_q;
    assign lock_pulse  = lock_pulse_q;
    assign period      = period_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
